// File: rtl/mole_round_scheduler_if.sv
// Board-side bundle for the whack-a-mole round scheduler.
// master: key/switch front end driving start/whack/sw and reading display data.
// slave : the scheduler itself.
interface mole_round_scheduler_if;
    logic        start;
    logic        whack;
    logic [9:0]  sw;
    logic [9:0]  led;
    logic [9:0]  react_ms;
    logic [1:0]  round_idx;
    logic        result_valid;
    logic [9:0]  result_ms;
    logic        hit;
    logic [9:0]  best_ms;
    logic [11:0] total_ms;
    logic        done;

    modport master (
        output start, whack, sw,
        input  led, react_ms, round_idx, result_valid, result_ms, hit,
               best_ms, total_ms, done
    );

    modport slave (
        input  start, whack, sw,
        output led, react_ms, round_idx, result_valid, result_ms, hit,
               best_ms, total_ms, done
    );
endinterface

// File: rtl/mole_round_scheduler.sv
// Multi-round whack-a-mole controller: random pre-mole delay, one lit mole,
// millisecond reaction timing, per-round judging and best/total tracking.
// Optional feature: define MOLE_EARLY_PENALTY_EN to treat a whack during the
// pre-mole delay as a false start (delay restarts, +100 ms penalty on total).
module mole_round_scheduler #(
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned ROUNDS       = 4,
    parameter int unsigned TIMEOUT_MS   = 999,
    parameter int unsigned DELAY_MIN_MS = 500
) (
    input  logic                 clk,
    input  logic                 resetn,
    mole_round_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SHOW,
        ST_SCORE,
        ST_DONE
    } state_t;

    localparam logic [19:0] DIV_LAST   = 20'(TICK_DIV - 1);
    localparam logic [9:0]  TIMEOUT    = 10'(TIMEOUT_MS);
    localparam logic [1:0]  LAST_ROUND = 2'(ROUNDS - 1);
    localparam logic [10:0] DELAY_MIN  = 11'(DELAY_MIN_MS);

    state_t      state;
    logic [9:0]  lfsr;
    logic [19:0] div;
    logic [10:0] ms_cnt;
    logic [10:0] target;
    logic [3:0]  mole_idx;

    logic [9:0]  led;
    logic [9:0]  react_ms;
    logic [1:0]  round_idx;
    logic        result_valid;
    logic [9:0]  result_ms;
    logic        hit;
    logic [9:0]  best_ms;
    logic [11:0] total_ms;
    logic        done;

    logic        tick;
    logic        whack_hit;
    logic        timed_out;
    logic [9:0]  score_val;
    logic [10:0] next_target;
    logic [3:0]  next_mole;
    logic [11:0] next_total;
`ifdef MOLE_EARLY_PENALTY_EN
    logic [12:0] score_sum;
    logic [12:0] pen_sum;
    logic [11:0] pen_total;
`endif

    // Per-cycle decode: tick, round-ending conditions, next delay/mole, totals
    always_comb begin
        tick        = (div == DIV_LAST);
        whack_hit   = bus.whack && (bus.sw == led);
        timed_out   = (react_ms == TIMEOUT);
        // On a same-cycle hit and timeout react_ms already equals TIMEOUT
        score_val   = whack_hit ? react_ms : TIMEOUT;
        next_target = DELAY_MIN + {2'b00, lfsr[8:0]};
        next_mole   = (lfsr[3:0] >= 4'd10) ? (lfsr[3:0] - 4'd10) : lfsr[3:0];
`ifdef MOLE_EARLY_PENALTY_EN
        score_sum   = {1'b0, total_ms} + {3'b000, score_val};
        next_total  = score_sum[12] ? '1 : score_sum[11:0];
        pen_sum     = {1'b0, total_ms} + 13'd100;
        pen_total   = pen_sum[12] ? '1 : pen_sum[11:0];
`else
        next_total  = total_ms + {2'b00, score_val};
`endif
    end

    // Game sequencer with registered outputs; LFSR and divider run every cycle
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            lfsr         <= 10'h001;
            div          <= '0;
            ms_cnt       <= '0;
            target       <= '0;
            mole_idx     <= '0;
            led          <= '0;
            react_ms     <= '0;
            round_idx    <= '0;
            result_valid <= 1'b0;
            result_ms    <= '0;
            hit          <= 1'b0;
            best_ms      <= '1;
            total_ms     <= '0;
            done         <= 1'b0;
        end else begin
            lfsr         <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
            div          <= tick ? '0 : div + 20'd1;
            result_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state     <= ST_WAIT;
                        div       <= '0;
                        ms_cnt    <= '0;
                        target    <= next_target;
                        mole_idx  <= next_mole;
                        round_idx <= '0;
                        best_ms   <= '1;
                        total_ms  <= '0;
                        react_ms  <= '0;
                        done      <= 1'b0;
                    end
                end
                ST_WAIT: begin
`ifdef MOLE_EARLY_PENALTY_EN
                    if (bus.whack) begin
                        div      <= '0;
                        ms_cnt   <= '0;
                        target   <= next_target;
                        mole_idx <= next_mole;
                        total_ms <= pen_total;
                    end else
`endif
                    if (ms_cnt == target) begin
                        state    <= ST_SHOW;
                        div      <= '0;
                        led      <= 10'd1 << mole_idx;
                        react_ms <= '0;
                    end else if (tick) begin
                        ms_cnt <= ms_cnt + 11'd1;
                    end
                end
                ST_SHOW: begin
                    if (whack_hit || timed_out) begin
                        state        <= ST_SCORE;
                        led          <= '0;
                        result_valid <= 1'b1;
                        result_ms    <= score_val;
                        hit          <= whack_hit;
                        total_ms     <= next_total;
                        if (score_val < best_ms)
                            best_ms <= score_val;
                    end else if (tick) begin
                        react_ms <= react_ms + 10'd1;
                    end
                end
                ST_SCORE: begin
                    if (round_idx == LAST_ROUND) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        state     <= ST_WAIT;
                        round_idx <= round_idx + 2'd1;
                        div       <= '0;
                        ms_cnt    <= '0;
                        target    <= next_target;
                        mole_idx  <= next_mole;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.led          = led;
    assign bus.react_ms     = react_ms;
    assign bus.round_idx    = round_idx;
    assign bus.result_valid = result_valid;
    assign bus.result_ms    = result_ms;
    assign bus.hit          = hit;
    assign bus.best_ms      = best_ms;
    assign bus.total_ms     = total_ms;
    assign bus.done         = done;

endmodule
